// File: rtl/counter_pkg.sv
// Shared definitions for the counter_intf counter family.
// Contents: default counter width, count-direction encoding and reset value.
package counter_pkg;

    // Default counter / data-bus width in bits.
    localparam int COUNTER_WIDTH = 4;

    // Decoding of the updown input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Count value forced by reset; truncated to the instance width by users.
    localparam logic [31:0] COUNT_RESET = '0;

endpackage : counter_pkg

// File: rtl/modport_counter_next.sv
// Combinational next-count logic for modport_counter.
// Ports:
//   load         - parallel-load request; overrides the count direction
//   updown       - count direction (1 = up, 0 = down)
//   data         - value loaded when load = 1
//   count        - current count
//   next_count_c - count to be registered at the next edge (combinational)
module modport_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = $unsigned(COUNTER_WIDTH)
) (
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next_count_c
);

    // Load wins over counting; arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        next_count_c = count;
        if (load) begin
            next_count_c = data;
        end else if (dir_e'(updown) == DIR_UP) begin
            next_count_c = count + WIDTH'(1);
        end else begin
            next_count_c = count - WIDTH'(1);
        end
    end

endmodule : modport_counter_next

// File: rtl/modport_counter.sv
// Synchronous up/down counter with parallel load; DUT behind counter_intf.
// Ports:
//   clk      - clock, all state changes on rising edge
//   rst      - synchronous active-high reset, clears the count
//   load     - parallel-load request (priority below rst)
//   updown   - count direction (1 = up, 0 = down)
//   data     - parallel-load value
//   data_out - current count, straight from the register
module modport_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = $unsigned(COUNTER_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] next_count_c;

    modport_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .load        (load),
        .updown      (updown),
        .data        (data),
        .count       (data_out),
        .next_count_c(next_count_c)
    );

    // Count register; reset takes precedence over load and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= WIDTH'(COUNT_RESET);
        end else begin
            data_out <= next_count_c;
        end
    end

    // Reset clears the count on the following edge.
    a_reset_clears: assert property (@(posedge clk)
        rst |=> (data_out == WIDTH'(COUNT_RESET)));

    // Without load the count moves by exactly one, wrapping.
    a_step_up: assert property (@(posedge clk) disable iff (rst)
        (!load && updown) |=> (data_out == $past(data_out) + WIDTH'(1)));

    a_step_down: assert property (@(posedge clk) disable iff (rst)
        (!load && !updown) |=> (data_out == $past(data_out) - WIDTH'(1)));

endmodule : modport_counter

// File: tb/tb_modport_counter.sv
// Directed self-checking bench for modport_counter at the default width.
module tb_modport_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic             updown;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_out;

    int n_checks = 0;
    int n_errors = 0;

    modport_counter #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .updown  (updown),
        .data    (data),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] act,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: data_out=%h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check data_out just after the edge.
    task automatic cycle(input logic r, input logic l, input logic u,
                         input logic [WIDTH-1:0] d, input string tag,
                         input logic [WIDTH-1:0] exp);
        rst    = r;
        load   = l;
        updown = u;
        data   = d;
        @(posedge clk);
        #1;
        check_eq(tag, data_out, exp);
    endtask

    initial begin
        // Reset beats load
        cycle(1'b1, 1'b1, 1'b1, 4'hA, "rst_ld0", 4'h0);
        cycle(1'b1, 1'b1, 1'b1, 4'hA, "rst_ld1", 4'h0);

        // Count up with wrap
        cycle(1'b0, 1'b1, 1'b0, 4'hE, "ld_e",  4'hE);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "up_f",  4'hF);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "up_0",  4'h0);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "up_1",  4'h1);

        // Count down with wrap from reset
        cycle(1'b1, 1'b0, 1'b0, 4'h0, "rst_dn", 4'h0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, "dn_f",  4'hF);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, "dn_e",  4'hE);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, "dn_d",  4'hD);

        // Load mid-count; updown ignored during load
        cycle(1'b0, 1'b1, 1'b1, 4'h2, "ld_2",  4'h2);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "up_3",  4'h3);
        cycle(1'b0, 1'b1, 1'b0, 4'h9, "ld_9",  4'h9);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, "dn_8",  4'h8);

        // Load of the current value holds
        cycle(1'b0, 1'b1, 1'b1, 4'h8, "hold_8", 4'h8);

        // Direction toggle
        cycle(1'b0, 1'b1, 1'b0, 4'h5, "ld_5",  4'h5);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "tg_6a", 4'h6);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, "tg_5a", 4'h5);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "tg_6b", 4'h6);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, "tg_5b", 4'h5);

        // Reset mid-operation discards a simultaneous load
        cycle(1'b0, 1'b1, 1'b0, 4'hA, "ld_a",  4'hA);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "up_b",  4'hB);
        cycle(1'b1, 1'b1, 1'b1, 4'h7, "rst_mid", 4'h0);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "rel_up1", 4'h1);

        // Load all-ones then count up wraps to zero
        cycle(1'b0, 1'b1, 1'b0, 4'hF, "ld_f",  4'hF);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, "wrap_0", 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_modport_counter
